// File: rtl/internal_to_ieee_packer.sv
// ---------------------------------------------------------------------------
// internal_to_ieee_packer
//
// Converts the FP library's exception-tagged internal word
//   {exc, sign, exponent, fraction-without-hidden-bit}
// back to an IEEE-754 binary interchange word {sign, exponent, fraction}.
// This block sits at the output boundary of the FP datapath.
//
// Pipeline: two registered stages.
//   S1 holds the decoded fields (class, sign, exponent, fraction) and v1.
//   S2 holds the packed IEEE word (and flags) and v2.
// It sustains one word per cycle and absorbs backpressure without loss.
//
// Handshake (both sides, strict valid/ready): a word moves across an
// interface on a rising edge where valid and ready are both high. A producer
// holding valid keeps its data stable until that edge. in_ready depends
// combinationally on out_ready, so a full pipe can accept a new word in the
// same cycle that it hands one downstream.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   in_valid       number_i holds a valid internal word
//   in_ready       block accepts number_i this cycle
//   number_i       internal word {exc, sign, exp, frac}
//   out_valid      ieee_number_o holds a valid result
//   out_ready      downstream consumes the result this cycle
//   ieee_number_o  IEEE word {sign, exp, frac}
//   flags_o        {invalid, overflow, underflow}       (PACKER_STATUS_FLAGS_EN)
//   flags_sticky_o OR of flags over all output transfers (PACKER_STATUS_FLAGS_EN)
//
// Optional feature: define PACKER_STATUS_FLAGS_EN to add flags_o and
// flags_sticky_o. Without it those ports and their flops are absent and the
// data behaviour is unchanged.
// ---------------------------------------------------------------------------
module internal_to_ieee_packer #(
    parameter int size_mantissa        = 24,
    parameter int size_exponent        = 8,
    parameter int size_exception_field = 2,
    parameter int zero                 = 0,
    parameter int normal_number        = 1,
    parameter int infinity             = 2,
    parameter int NaN                  = 3,
    parameter int size                 = size_mantissa + size_exponent + size_exception_field,
    parameter int ieee_size            = size_mantissa + size_exponent
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [size-1:0]      number_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ieee_size-1:0] ieee_number_o
`ifdef PACKER_STATUS_FLAGS_EN
    ,
    output logic [2:0]           flags_o,
    output logic [2:0]           flags_sticky_o
`endif
);

    localparam int frac_w = size_mantissa - 1;

    localparam logic [size_exponent-1:0] exp_max  = '1;
    localparam logic [size_exponent-1:0] exp_zero = '0;
    localparam logic [frac_w-1:0]        frac_zero = '0;
    // Quiet NaN: only the top fraction bit set, i.e. 1 << (size_mantissa-2).
    localparam logic [frac_w-1:0]        qnan_frac = {1'b1, {(frac_w-1){1'b0}}};

    typedef enum logic [1:0] {
        cls_zero   = 2'd0,
        cls_normal = 2'd1,
        cls_inf    = 2'd2,
        cls_nan    = 2'd3
    } num_class_t;

    // ---------------------------------------------------------------------
    // Input field split and class decode
    // ---------------------------------------------------------------------
    logic [size_exception_field-1:0] in_exc;
    logic                            in_sign;
    logic [size_exponent-1:0]        in_exp;
    logic [frac_w-1:0]               in_frac;
    num_class_t                      in_class;

    assign in_exc  = number_i[size-1 -: size_exception_field];
    assign in_sign = number_i[ieee_size-1];
    assign in_exp  = number_i[ieee_size-2 -: size_exponent];
    assign in_frac = number_i[frac_w-1:0];

    // Any code outside the four known ones (only possible for wider exception
    // fields) is treated as NaN.
    always_comb begin
        in_class = cls_nan;
        if (in_exc == size_exception_field'(zero))
            in_class = cls_zero;
        else if (in_exc == size_exception_field'(normal_number))
            in_class = cls_normal;
        else if (in_exc == size_exception_field'(infinity))
            in_class = cls_inf;
        else if (in_exc == size_exception_field'(NaN))
            in_class = cls_nan;
    end

    // ---------------------------------------------------------------------
    // Handshake control
    // ---------------------------------------------------------------------
    logic v1;
    logic v2;
    logic adv2;
    logic accept;

    assign adv2      = v1 & (~v2 | out_ready);
    assign in_ready  = ~v1 | adv2;
    assign accept    = in_valid & in_ready;
    assign out_valid = v2;

    // ---------------------------------------------------------------------
    // Stage 1: decoded fields
    // ---------------------------------------------------------------------
    num_class_t               s1_class;
    logic                     s1_sign;
    logic [size_exponent-1:0] s1_exp;
    logic [frac_w-1:0]        s1_frac;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            s1_class <= cls_zero;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_frac  <= '0;
        end else begin
            v1 <= accept | (v1 & ~adv2);
            if (accept) begin
                s1_class <= in_class;
                s1_sign  <= in_sign;
                s1_exp   <= in_exp;
                s1_frac  <= in_frac;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Packing logic between S1 and S2
    // ---------------------------------------------------------------------
    logic [ieee_size-1:0] pack_word;
`ifdef PACKER_STATUS_FLAGS_EN
    logic [2:0]           pack_flags;   // {invalid, overflow, underflow}
`endif

    always_comb begin
        pack_word = '0;
`ifdef PACKER_STATUS_FLAGS_EN
        pack_flags = 3'b000;
`endif
        case (s1_class)
            cls_zero: begin
                pack_word = {s1_sign, exp_zero, frac_zero};
            end
            cls_inf: begin
                pack_word = {s1_sign, exp_max, frac_zero};
            end
            cls_nan: begin
                // Sign kept, payload dropped.
                pack_word = {s1_sign, exp_max, qnan_frac};
`ifdef PACKER_STATUS_FLAGS_EN
                pack_flags = 3'b100;
`endif
            end
            cls_normal: begin
                if (s1_exp == exp_max) begin
                    // A "normal" that reached the all-ones exponent saturates to infinity.
                    pack_word = {s1_sign, exp_max, frac_zero};
`ifdef PACKER_STATUS_FLAGS_EN
                    pack_flags = 3'b010;
`endif
                end else if (s1_exp == exp_zero) begin
                    // No subnormal output: flush to signed zero.
                    pack_word = {s1_sign, exp_zero, frac_zero};
`ifdef PACKER_STATUS_FLAGS_EN
                    pack_flags = 3'b001;
`endif
                end else begin
                    pack_word = {s1_sign, s1_exp, s1_frac};
                end
            end
            default: begin
                pack_word = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Stage 2: packed output word (held while stalled)
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2            <= 1'b0;
            ieee_number_o <= '0;
`ifdef PACKER_STATUS_FLAGS_EN
            flags_o       <= 3'b000;
`endif
        end else begin
            v2 <= adv2 | (v2 & ~out_ready);
            if (adv2) begin
                ieee_number_o <= pack_word;
`ifdef PACKER_STATUS_FLAGS_EN
                flags_o       <= pack_flags;
`endif
            end
        end
    end

`ifdef PACKER_STATUS_FLAGS_EN
    // Accumulates flags of every word actually handed downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_sticky_o <= 3'b000;
        end else if (v2 & out_ready) begin
            flags_sticky_o <= flags_sticky_o | flags_o;
        end
    end
`endif

endmodule

// File: tb/tb_internal_to_ieee_packer.sv
// ---------------------------------------------------------------------------
// tb_internal_to_ieee_packer
//
// Bench for internal_to_ieee_packer (default 34-bit internal / 32-bit IEEE).
// Stimulus is driven 1 time unit after the rising edge; outputs are sampled
// on the falling edge. Expected {flags, ieee} words are pushed when a word is
// accepted and popped when the DUT hands one downstream.
// Flag checks are active when PACKER_STATUS_FLAGS_EN is defined.
// ---------------------------------------------------------------------------
module tb_internal_to_ieee_packer;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [33:0] number_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ieee_number_o;
`ifdef PACKER_STATUS_FLAGS_EN
    logic [2:0]  flags_o;
    logic [2:0]  flags_sticky_o;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    internal_to_ieee_packer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .number_i      (number_i),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .ieee_number_o (ieee_number_o)
`ifdef PACKER_STATUS_FLAGS_EN
        ,
        .flags_o       (flags_o),
        .flags_sticky_o(flags_sticky_o)
`endif
    );

    // ---------------- bookkeeping ----------------
    int          checks   = 0;
    int          failures = 0;
    int          out_cnt  = 0;
    logic [34:0] exp_q[$];       // {flags, ieee}

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference conversion, written straight from the format description.
    function automatic logic [34:0] model(input logic [33:0] w);
        logic [1:0]  exc;
        logic        s;
        logic [7:0]  e;
        logic [34:0] r;
        exc = w[33:32];
        s   = w[31];
        e   = w[30:23];
        case (exc)
            2'd0:    r = {3'b000, s, 8'h00, 23'h000000};
            2'd2:    r = {3'b000, s, 8'hFF, 23'h000000};
            2'd3:    r = {3'b100, s, 8'hFF, 23'h400000};
            default: begin
                if (e == 8'hFF)      r = {3'b010, s, 8'hFF, 23'h000000};
                else if (e == 8'h00) r = {3'b001, s, 8'h00, 23'h000000};
                else                 r = {3'b000, w[31:0]};
            end
        endcase
        return r;
    endfunction

    function automatic logic [33:0] rand_word();
        logic [33:0] w;
        w[33:32] = 2'($urandom_range(0, 3));
        w[31:0]  = $urandom();
        return w;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic        stall_seen = 1'b0;
    logic [31:0] held_word;
    logic [2:0]  held_flags;

    always @(negedge clk) begin
        logic [34:0] e;
        if (!rst_n) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen) begin
                check("hold_valid", out_valid, 1);
                check("hold_word", ieee_number_o, held_word);
`ifdef PACKER_STATUS_FLAGS_EN
                check("hold_flags", flags_o, held_flags);
`endif
            end
            if (out_valid && out_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", ieee_number_o, e[31:0]);
`ifdef PACKER_STATUS_FLAGS_EN
                    check("out_flags", flags_o, e[34:32]);
`endif
                end
            end
            stall_seen = out_valid && !out_ready;
            held_word  = ieee_number_o;
`ifdef PACKER_STATUS_FLAGS_EN
            held_flags = flags_o;
`else
            held_flags = 3'b000;
`endif
            if (in_valid && in_ready)
                exp_q.push_back(model(number_i));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_word(input logic [33:0] w);
        bit acc;
        int budget;
        acc      = 0;
        budget   = 0;
        number_i = w;
        in_valid = 1'b1;
        while (!acc && budget < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Watchdog: keeps the run bounded whatever the DUT does.
    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [33:0] bp_w[5];
        logic [33:0] w2;
        int          j;
        int          cnt0;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        number_i  = '0;

        // Reset state
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_word", ieee_number_o, 0);
`ifdef PACKER_STATUS_FLAGS_EN
        check("rst_flags", flags_o, 0);
        check("rst_sticky", flags_sticky_o, 0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);

        // Pass-through 1.0 and latency
        out_ready = 1'b1;
        number_i  = 34'h13F800000;
        in_valid  = 1'b1;
        @(negedge clk);
        check("pt_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("pt_lat_not_yet", out_valid, 0);
        @(negedge clk);
        check("pt_lat_valid", out_valid, 1);
        check("pt_word", ieee_number_o, 32'h3F800000);
        @(posedge clk);
        #1;

        // Exponent boundaries
        send_word(34'h17F800000);
        send_word(34'h100400000);
        idle(4);
`ifdef PACKER_STATUS_FLAGS_EN
        check("sticky_boundaries", flags_sticky_o, 3'b011);
`endif

        // Specials back-to-back
        send_word(34'h280000000);
        send_word(34'h300000000);
        send_word(34'h080000000);
        idle(4);

        // Backpressure: 5 words, out_ready low for 4 cycles
        for (int k = 0; k < 5; k++) bp_w[k] = rand_word();
        j = 0;
        for (int cyc = 0; cyc < 40 && j < 5; cyc++) begin
            out_ready = (cyc >= 4);
            number_i  = bp_w[j];
            in_valid  = 1'b1;
            @(negedge clk);
            if (cyc == 2) begin
                check("bp_accepts_before_drop", j, 2);
                check("bp_in_ready_low", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
            end
            if (in_ready) j++;
            @(posedge clk);
            #1;
        end
        check("bp_all_accepted", j, 5);
        out_ready = 1'b1;
        idle(6);

        // Throughput: 16 words back-to-back
        cnt0 = out_cnt;
        for (int i = 0; i < 16; i++) begin
            number_i = rand_word();
            in_valid = 1'b1;
            @(negedge clk);
            check("tp_in_ready", in_ready, 1);
            if (i >= 2) check("tp_out_valid", out_valid, 1);
            @(posedge clk);
            #1;
        end
        idle(3);
        check("tp_out_count", out_cnt - cnt0, 16);

        // Reset mid-operation with 2 words in flight
        out_ready = 1'b0;
        send_word(rand_word());
        send_word(rand_word());
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_word", ieee_number_o, 0);
`ifdef PACKER_STATUS_FLAGS_EN
        check("mid_rst_flags", flags_o, 0);
`endif
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_no_stale", out_valid, 0);
        out_ready = 1'b1;
        cnt0 = out_cnt;
        w2 = 34'h1C0A00001;      // normal, -5.0 with a low fraction bit
        send_word(w2);
        idle(4);
        check("post_rst_out_count", out_cnt - cnt0, 1);
`ifdef PACKER_STATUS_FLAGS_EN
        check("post_rst_sticky", flags_sticky_o, 3'b000);
`endif

        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/internal_to_ieee_packer.md
Name: internal_to_ieee_packer

Overview:
- Converts results in the library's exception-tagged internal float format {exception_field, sign, exponent, mantissa-without-hidden-bit} back to IEEE-754 binary interchange format. The adder and the other arithmetic cores produce this internal format.
- Sits at the output boundary of the FP datapath, opposite the unpack stage that feeds the cores.
- Two-stage registered pipeline with valid/ready handshakes on both sides. Full throughput of one result per cycle; tolerates backpressure without loss.

Parameters:
- size_mantissa, 24, mantissa width including hidden 1 (1.M).
- size_exponent, 8, biased exponent width.
- size_exception_field, 2, exception tag width.
- zero, 0, exception code for zero.
- normal_number, 1, exception code for normal.
- infinity, 2, exception code for infinity.
- NaN, 3, exception code for NaN.
- size, size_mantissa+size_exponent+size_exception_field, internal word width (34).
- ieee_size, size_mantissa+size_exponent, IEEE word width (32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  number_i holds a valid internal word.
- in_ready  output  1  block accepts number_i this cycle.
- number_i  input  size  internal word, layout {exc[size-1:size-2], sign, exp, frac[size_mantissa-2:0]}.
- out_valid  output  1  ieee_number_o holds a valid result.
- out_ready  input  1  downstream consumes the result this cycle.
- ieee_number_o  output  ieee_size  IEEE word {sign, exp, frac}.
- flags_o  output  3  {invalid, overflow, underflow}. Present only with the optional feature.

Behaviour:
- Clock and reset are fixed: single clock clk; rst_n is asynchronous and active-low.
- Stage 1 (S1) registers the decoded fields: class, sign, exponent, fraction, plus valid bit v1.
- Stage 2 (S2) registers the packed IEEE word, plus valid bit v2. out_valid = v2, and ieee_number_o is driven directly from the S2 register.
- Advance rules:
  - adv2 = v1 & (!v2 | out_ready).
  - in_ready = !v1 | adv2. This is a combinational path from out_ready; it is permitted.
  - A transfer occurs when in_valid & in_ready.
- Latency: a word accepted on edge k is loaded into S2 on edge k+1. out_valid is high from edge k+1 onward, giving 2-cycle latency with no stalls.
- While out_valid & !out_ready, ieee_number_o and flags_o hold stable.
- Maximum occupancy is 2 words. Order is strictly preserved; no drop or duplication.
- Simultaneous accept and advance in the same cycle is legal and sustains 1 word/cycle.
- Conversion, with e = internal exponent and emax = all ones:
  - zero: {s, 0, 0}.
  - infinity: {s, emax, 0}.
  - NaN: {s, emax, 1 << (size_mantissa-2)}. This is a quiet NaN with sign preserved and payload discarded; invalid=1.
  - normal, 0 < e < emax: {s, e, frac}, passed bit-exact.
  - normal, e == emax: {s, emax, 0}; overflow=1.
  - normal, e == 0: {s, 0, 0}, flushed because no subnormals are produced; underflow=1.
  - Unlisted exception codes cannot occur for a 2-bit field. Wider fields decode any other code as NaN.
- Reset, asynchronous at any time including mid-transfer:
  - v1=0, v2=0, out_valid=0, ieee_number_o=0, flags_o=0, all S1 fields 0.
  - In-flight words are discarded.
  - in_ready=1 in the first cycle after release.

Optional Feature:
- Macro: PACKER_STATUS_FLAGS_EN.
- When defined:
  - flags_o exists and is registered in S2 alongside ieee_number_o, under the same hold rules.
  - Sticky register flags_sticky_o (3 bits, output) ORs in flags on every output transfer (out_valid & out_ready).
  - flags_sticky_o is cleared only by reset.
- When undefined: flags_o and flags_sticky_o ports and all associated flops are absent. Data behaviour is identical.

Test Plan:
- Normal pass-through: number_i=0x13F800000 (1.0) with out_ready=1 -> 0x3F800000 two edges after accept.
- Specials in back-to-back cycles:
  - 0x280000000 (-inf) -> 0xFF800000.
  - 0x300000000 (+NaN) -> 0x7FC00000, flags 3'b100.
  - 0x080000000 (-0) -> 0x80000000.
- Exponent boundaries:
  - 0x17F800000 (normal, e=0xFF) -> 0x7F800000, flags 3'b010.
  - 0x100400000 (normal, e=0) -> 0x00000000, flags 3'b001.
  - With the macro, flags_sticky_o ends at 3'b011.
- Backpressure: offer 5 consecutive words while out_ready=0 for 4 cycles, then 1.
  - in_ready drops after 2 accepts; out_valid and data hold stable while stalled.
  - All 5 results emerge in order with none repeated.
- Throughput: 16 words streamed with in_valid=out_ready=1 -> one result per cycle after 2-cycle fill; in_ready never drops.
- Reset mid-operation: assert rst_n=0 between edges with 2 words in flight.
  - out_valid, ieee_number_o and flags fall to 0 immediately.
  - After release, the next accepted word emerges correctly with no stale output.
